// File: rtl/part2_mac_if.sv
// Sample/result bundle for the sum-of-squares accumulator.
//   a         : signed 8-bit sample from the source
//   valid_in  : a is valid this cycle
//   f         : accumulated sum of squares, unsigned 20-bit
//   valid_out : f was updated on the most recent clock edge
// master = sample source / result consumer, slave = accumulator.
interface part2_mac_if;
  logic [7:0]  a;
  logic        valid_in;
  logic [19:0] f;
  logic        valid_out;

  modport master (
    output a,
    output valid_in,
    input  f,
    input  valid_out
  );

  modport slave (
    input  a,
    input  valid_in,
    output f,
    output valid_out
  );
endinterface

// File: rtl/part2_mac.sv
// part2_mac: registered sum-of-squares accumulator, datapath core of the
// L2-norm engine. Stage 1 registers the sample and its valid flag; stage 2
// squares the registered sample and adds it to a 20-bit running total that
// wraps modulo 2^20. Only reset clears the total.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-high; clears every register
//   bus   : part2_mac_if.slave (a, valid_in in; f, valid_out out)
module part2_mac (
  input  logic              clk,
  input  logic              reset,
  part2_mac_if.slave        bus
);

  logic signed [7:0]  a_r;
  logic               en_r;
  logic [19:0]        f_r;
  logic               valid_out_r;
  logic signed [15:0] prod;
  logic [19:0]        prod_ext;

  // Stage 1: sampled unconditionally; en_r gates the accumulate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r  <= '0;
      en_r <= 1'b0;
    end else begin
      a_r  <= bus.a;
      en_r <= bus.valid_in;
    end
  end

  // A square is never negative (max 16384), so zero-extension is exact.
  assign prod     = a_r * a_r;
  assign prod_ext = {4'b0000, prod};

  // Stage 2: accumulate modulo 2^20, no saturation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      f_r         <= '0;
      valid_out_r <= 1'b0;
    end else begin
      if (en_r) begin
        f_r <= f_r + prod_ext;
      end
      valid_out_r <= en_r;
    end
  end

  assign bus.f         = f_r;
  assign bus.valid_out = valid_out_r;

endmodule

// File: tb/tb_part2_mac.sv
module tb_part2_mac;

  logic clk;
  logic reset;

  part2_mac_if bus ();

  part2_mac dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int unsigned f;
    int unsigned cyc;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;
  int unsigned edges = 0;
  int unsigned model = 0;   // reference running total
  int unsigned hold_f = 0;  // last total the monitor has confirmed

  always @(posedge clk) edges++;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present one sample after the next edge; a valid one lands in f two edges later.
  task automatic drive(input logic v, input int val);
    @(posedge clk);
    #1;
    bus.valid_in = v;
    bus.a        = val[7:0];
    if (v) begin
      model = (model + int'(val * val)) % 1048576;
      sb.push_back('{f: model, cyc: edges + 2});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, int'($urandom_range(0, 255)) - 128);
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    bus.a        = '0;
    #2;
    reset = 1'b1;
    model = 0;
    #1;
    check("async_reset_f", bus.f, 0);
    check("async_reset_valid_out", bus.valid_out, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // Monitor: pops expectations when valid_out is seen, checks f is held otherwise.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        check("reset_f", bus.f, 0);
        check("reset_valid_out", bus.valid_out, 0);
        sb.delete();
        hold_f = 0;
      end else if (bus.valid_out) begin
        if (sb.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid_out: got valid_out=1 f=%0d expected valid_out=0 (t=%0t)",
                   bus.f, $time);
        end else begin
          e = sb.pop_front();
          check("f_value", bus.f, e.f);
          check("valid_out_edge", edges, e.cyc);
          hold_f = e.f;
        end
      end else begin
        check("f_held", bus.f, hold_f);
        if (sb.size() > 0 && sb[0].cyc <= edges) begin
          e = sb.pop_front();
          total++;
          bad++;
          $display("FAIL missing_valid_out: got valid_out=0 expected 1 at edge %0d (f=%0d)",
                   e.cyc, e.f);
        end
      end
    end
  end

  initial begin
    reset        = 1'b1;
    bus.valid_in = 1'b0;
    bus.a        = '0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    check("post_reset_f", bus.f, 0);
    check("post_reset_valid_out", bus.valid_out, 0);

    // valid/invalid mix
    drive(1'b1, 3);
    drive(1'b0, 5);
    drive(1'b1, -4);
    idle(2);
    check("mix_total", bus.f, 25);

    // single pulses with gaps of 0..5 cycles
    for (int g = 0; g <= 5; g++) begin
      drive(1'b1, 10);
      idle(g);
    end
    idle(2);
    check("sweep_total", bus.f, 625);

    // invalid data across the full range never touches f
    for (int i = 0; i < 20; i++) drive(1'b0, -128 + i * 13);
    idle(2);
    check("invalid_total", bus.f, 625);

    // overflow wrap
    do_reset();
    for (int i = 0; i < 63; i++) drive(1'b1, -128);
    idle(2);
    check("overflow_63", bus.f, 1032192);
    drive(1'b1, -128);
    idle(2);
    check("overflow_wrap", bus.f, 0);
    drive(1'b1, 2);
    idle(2);
    check("after_wrap", bus.f, 4);

    // sign handling
    do_reset();
    drive(1'b1, 127);
    idle(2);
    check("sign_127", bus.f, 16129);
    drive(1'b1, -1);
    idle(2);
    check("sign_minus1", bus.f, 16130);

    // random traffic, then reset while samples are in flight
    for (int i = 0; i < 400; i++)
      drive(1'($urandom_range(0, 1)), int'($urandom_range(0, 255)) - 128);
    drive(1'b1, 77);
    drive(1'b1, -50);
    do_reset();
    for (int i = 0; i < 200; i++)
      drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)) - 128);
    idle(4);
    check("scoreboard_drained", sb.size(), 0);
    check("final_total", bus.f, model);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
